// File: rtl/player_bullet_ctrl_if.sv
// ---------------------------------------------------------------------------
// player_bullet_ctrl_if
// Bundles the fire/hit inputs and the per-slot bullet outputs of
// player_bullet_ctrl.
//   master : player/collision side; drives shoot_bullet, player_X, hit_valid
//            and hit_idx, and observes the bullet outputs
//   slave  : the bullet controller
// Signals:
//   shoot_bullet   fire request level
//   player_X       player centre X, sampled at spawn
//   hit_valid      collision stage reports a hit on slot hit_idx
//   hit_idx        slot index qualified by hit_valid
//   bullet_X/Y     packed 10-bit position per slot (slot 0 in [9:0])
//   bullet_active  1 = slot in flight
//   fire_event     one-frame pulse on a successful spawn
//   ready          cooldown expired and at least one slot free
// ---------------------------------------------------------------------------
interface player_bullet_ctrl_if #(
   parameter int NUM_BULLETS = 2
);
   localparam int IDXW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

   logic                       shoot_bullet;
   logic [9:0]                 player_X;
   logic                       hit_valid;
   logic [IDXW-1:0]            hit_idx;
   logic [NUM_BULLETS*10-1:0]  bullet_X;
   logic [NUM_BULLETS*10-1:0]  bullet_Y;
   logic [NUM_BULLETS-1:0]     bullet_active;
   logic                       fire_event;
   logic                       ready;

   modport master (
      output shoot_bullet, player_X, hit_valid, hit_idx,
      input  bullet_X, bullet_Y, bullet_active, fire_event, ready
   );

   modport slave (
      input  shoot_bullet, player_X, hit_valid, hit_idx,
      output bullet_X, bullet_Y, bullet_active, fire_event, ready
   );
endinterface

// File: rtl/player_bullet_ctrl.sv
// ---------------------------------------------------------------------------
// player_bullet_ctrl
// Turns the player's shoot_bullet level into a bounded set of upward-moving
// bullets. Each slot spawns at the current player_X, moves up BULLET_STEP
// pixels per frame and retires on a reported hit or when it leaves the top
// of the screen. A cooldown timer throttles the fire rate.
// Ports:
//   frame_clk   one rising edge per video frame
//   Reset       asynchronous, active-high; clears all state
//   bus         player_bullet_ctrl_if slave modport (fire/hit in, bullets out)
//
// Per-slot state:
//   state | meaning
//   IDLE  | slot free, eligible for spawn
//   FLY   | bullet in flight, moves each frame
// ---------------------------------------------------------------------------
module player_bullet_ctrl #(
   parameter int NUM_BULLETS     = 2,
   parameter int BULLET_Y_START  = 440,
   parameter int BULLET_Y_MIN    = 0,
   parameter int BULLET_STEP     = 4,
   parameter int COOLDOWN_FRAMES = 8
) (
   input logic                  frame_clk,
   input logic                  Reset,
   player_bullet_ctrl_if.slave  bus
);
   localparam int IDXW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
   localparam int CDW  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

   localparam logic [CDW-1:0] CD_LOAD  = CDW'(COOLDOWN_FRAMES);
   localparam logic [9:0]     Y_START  = 10'(BULLET_Y_START);
   localparam logic [9:0]     Y_STEP   = 10'(BULLET_STEP);
   // Lowest Y from which a full step still lands at or below the top row;
   // comparing against this avoids ever computing a wrapping subtraction.
   localparam logic [9:0]     Y_THRESH = 10'(BULLET_Y_MIN + BULLET_STEP);

   typedef enum logic {IDLE = 1'b0, FLY = 1'b1} state_t;

   state_t                     slot_state [NUM_BULLETS];
   logic [NUM_BULLETS*10-1:0]  x_r;
   logic [NUM_BULLETS*10-1:0]  y_r;
   logic [CDW-1:0]             cooldown;
   logic                       shoot_d;
   logic                       fire_event_r;

   logic [NUM_BULLETS-1:0]     active;
   logic                       free_found;
   logic [IDXW-1:0]            free_idx;
   logic                       request;
   logic                       accept;

   always_comb begin
      active = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         active[i] = (slot_state[i] == FLY);
      end
   end

   // Lowest-index free slot, taken from last frame's registered flags so a
   // slot retired this frame is not reused until the next one.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
         if (!active[i]) begin
            free_found = 1'b1;
            free_idx   = IDXW'(i);
         end
      end
   end

   assign request = bus.shoot_bullet & ~shoot_d;
   assign accept  = request && (cooldown == '0) && free_found;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_BULLETS; i++) begin
            slot_state[i] <= IDLE;
         end
         x_r          <= '0;
         y_r          <= '0;
         cooldown     <= '0;
         shoot_d      <= 1'b0;
         fire_event_r <= 1'b0;
      end else begin
         shoot_d      <= bus.shoot_bullet;
         fire_event_r <= accept;

         if (accept) begin
            cooldown <= CD_LOAD;
         end else if (cooldown != '0) begin
            cooldown <= cooldown - CDW'(1);
         end

         for (int i = 0; i < NUM_BULLETS; i++) begin
            if (slot_state[i] == IDLE) begin
               if (accept && (free_idx == IDXW'(i))) begin
                  slot_state[i]     <= FLY;
                  x_r[i*10 +: 10]   <= bus.player_X;
                  y_r[i*10 +: 10]   <= Y_START;
               end
            end else if (bus.hit_valid && (bus.hit_idx == IDXW'(i))) begin
               slot_state[i] <= IDLE;
            end else if (y_r[i*10 +: 10] >= Y_THRESH) begin
               y_r[i*10 +: 10] <= y_r[i*10 +: 10] - Y_STEP;
            end else begin
               // Top exit: position holds its last value.
               slot_state[i] <= IDLE;
            end
         end
      end
   end

   assign bus.bullet_X      = x_r;
   assign bus.bullet_Y      = y_r;
   assign bus.bullet_active = active;
   assign bus.fire_event    = fire_event_r;
   assign bus.ready         = (cooldown == '0) && free_found;

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_bullet_ctrl
// Directed bench: a table of per-frame stimulus and expected outputs for the
// main fire/cooldown/hit timeline, plus hand-written sequences for held
// shoot, top-of-screen retirement and asynchronous reset mid-flight.
// ---------------------------------------------------------------------------
module tb_player_bullet_ctrl;
   logic frame_clk = 1'b0;
   logic Reset     = 1'b1;

   always #5 frame_clk = ~frame_clk;

   player_bullet_ctrl_if #(.NUM_BULLETS(2)) bus ();
   player_bullet_ctrl_if #(.NUM_BULLETS(2)) bus2 ();

   player_bullet_ctrl #(.NUM_BULLETS(2)) u_dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus)
   );

   // Second instance with a low spawn row so the Y=3 top exit is reachable.
   player_bullet_ctrl #(.NUM_BULLETS(2), .BULLET_Y_START(11)) u_dut2 (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus2)
   );

   assign bus2.shoot_bullet = bus.shoot_bullet;
   assign bus2.player_X     = bus.player_X;
   assign bus2.hit_valid    = bus.hit_valid;
   assign bus2.hit_idx      = bus.hit_idx;

   typedef struct {
      logic       shoot;
      logic [9:0] px;
      logic       hv;
      logic       hi;
      logic [1:0] act;
      logic       fire;
      logic       rdy;
      logic [9:0] x0, y0, x1, y1;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic void add(logic shoot, logic [9:0] px, logic hv, logic hi,
                               logic [1:0] act, logic fire, logic rdy,
                               logic [9:0] x0, logic [9:0] y0,
                               logic [9:0] x1, logic [9:0] y1);
      vec_t v;
      v.shoot = shoot; v.px = px; v.hv = hv; v.hi = hi;
      v.act = act; v.fire = fire; v.rdy = rdy;
      v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1;
      vq.push_back(v);
   endfunction

   task automatic check(string nm, logic [1:0] act, logic fire, logic rdy,
                        logic [9:0] x0, logic [9:0] y0,
                        logic [9:0] x1, logic [9:0] y1);
      n_vec++;
      if (bus.bullet_active !== act) begin
         n_err++;
         $display("FAIL %s active got %b want %b", nm, bus.bullet_active, act);
      end
      if (bus.fire_event !== fire) begin
         n_err++;
         $display("FAIL %s fire_event got %b want %b", nm, bus.fire_event, fire);
      end
      if (bus.ready !== rdy) begin
         n_err++;
         $display("FAIL %s ready got %b want %b", nm, bus.ready, rdy);
      end
      if (act[0] && (bus.bullet_X[9:0] !== x0 || bus.bullet_Y[9:0] !== y0)) begin
         n_err++;
         $display("FAIL %s slot0 got X=%0d Y=%0d want X=%0d Y=%0d", nm,
                  bus.bullet_X[9:0], bus.bullet_Y[9:0], x0, y0);
      end
      if (act[1] && (bus.bullet_X[19:10] !== x1 || bus.bullet_Y[19:10] !== y1)) begin
         n_err++;
         $display("FAIL %s slot1 got X=%0d Y=%0d want X=%0d Y=%0d", nm,
                  bus.bullet_X[19:10], bus.bullet_Y[19:10], x1, y1);
      end
   endtask

   task automatic do_reset();
      Reset            = 1'b1;
      bus.shoot_bullet = 1'b0;
      bus.player_X     = '0;
      bus.hit_valid    = 1'b0;
      bus.hit_idx      = '0;
      repeat (2) @(posedge frame_clk);
      @(negedge frame_clk);
      Reset = 1'b0;
   endtask

   task automatic frame(logic shoot, logic [9:0] px, logic hv, logic hi);
      bus.shoot_bullet = shoot;
      bus.player_X     = px;
      bus.hit_valid    = hv;
      bus.hit_idx      = hi;
      @(posedge frame_clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fires;

      // Rows are frames 1..33 after reset.
      add(1, 320, 0, 0, 2'b01, 1, 0, 320, 440, 0, 0);
      add(1, 320, 0, 0, 2'b01, 0, 0, 320, 436, 0, 0);
      add(0,   0, 0, 0, 2'b01, 0, 0, 320, 432, 0, 0);
      add(1, 100, 0, 0, 2'b01, 0, 0, 320, 428, 0, 0);
      for (int n = 5; n <= 8; n++)
         add(0, 0, 0, 0, 2'b01, 0, 0, 320, 10'(440 - 4*(n-1)), 0, 0);
      add(0,   0, 0, 0, 2'b01, 0, 1, 320, 408, 0, 0);
      add(1, 200, 0, 0, 2'b11, 1, 0, 320, 404, 200, 440);
      for (int n = 11; n <= 18; n++)
         add(0, 0, 0, 0, 2'b11, 0, 0, 320, 10'(440 - 4*(n-1)), 200, 10'(440 - 4*(n-10)));
      add(1,  50, 0, 0, 2'b11, 0, 0, 320, 368, 200, 404);
      add(0,   0, 1, 0, 2'b10, 0, 1,   0,   0, 200, 400);
      add(1,  60, 0, 0, 2'b11, 1, 0,  60, 440, 200, 396);
      for (int n = 22; n <= 29; n++)
         add(0, 0, 0, 0, 2'b11, 0, 0, 60, 10'(440 - 4*(n-21)), 200, 10'(440 - 4*(n-10)));
      add(1,  70, 1, 0, 2'b10, 0, 1,   0,   0, 200, 360);
      add(0,   0, 0, 0, 2'b10, 0, 1,   0,   0, 200, 356);
      add(1,  80, 1, 1, 2'b01, 1, 0,  80, 440,   0,   0);
      add(0,   0, 1, 1, 2'b01, 0, 0,  80, 436,   0,   0);

      do_reset();
      #1;
      check("reset_state", 2'b00, 0, 1, 0, 0, 0, 0);
      n_vec++;
      if (bus.bullet_X !== '0 || bus.bullet_Y !== '0) begin
         n_err++;
         $display("FAIL reset_pos got X=%h Y=%h want 0", bus.bullet_X, bus.bullet_Y);
      end

      for (int i = 0; i < vq.size(); i++) begin
         frame(vq[i].shoot, vq[i].px, vq[i].hv, vq[i].hi);
         check($sformatf("vec%0d", i + 1), vq[i].act, vq[i].fire, vq[i].rdy,
               vq[i].x0, vq[i].y0, vq[i].x1, vq[i].y1);
      end

      // Held shoot for 40 frames fires exactly once.
      do_reset();
      fires = 0;
      for (int n = 0; n < 40; n++) begin
         frame(1, 123, 0, 0);
         if (bus.fire_event === 1'b1) fires++;
      end
      n_vec++;
      if (fires != 1) begin
         n_err++;
         $display("FAIL hold_fire count got %0d want 1", fires);
      end

      // Top exit: default instance from Y=4 and the low-start instance from Y=3.
      do_reset();
      frame(1, 7, 0, 0);
      for (int n = 2; n <= 112; n++) begin
         frame(0, 0, 0, 0);
         if (n == 3) begin
            n_vec++;
            if (bus2.bullet_active !== 2'b01 || bus2.bullet_Y[9:0] !== 10'd3) begin
               n_err++;
               $display("FAIL y3_flight got act=%b Y=%0d want act=01 Y=3",
                        bus2.bullet_active, bus2.bullet_Y[9:0]);
            end
         end
         if (n == 4) begin
            n_vec++;
            if (bus2.bullet_active !== 2'b00 || bus2.bullet_Y[9:0] !== 10'd3) begin
               n_err++;
               $display("FAIL y3_exit got act=%b Y=%0d want act=00 Y=3",
                        bus2.bullet_active, bus2.bullet_Y[9:0]);
            end
         end
         if (n == 110) check("y4", 2'b01, 0, 1, 7, 4, 0, 0);
         if (n == 111) check("y0", 2'b01, 0, 1, 7, 0, 0, 0);
         if (n == 112) begin
            check("y0_exit", 2'b00, 0, 1, 0, 0, 0, 0);
            n_vec++;
            if (bus.bullet_Y[9:0] !== 10'd0) begin
               n_err++;
               $display("FAIL y0_hold got Y=%0d want 0", bus.bullet_Y[9:0]);
            end
         end
      end

      // Asynchronous reset between edges, right after a fire.
      do_reset();
      frame(1, 500, 0, 0);
      check("pre_reset", 2'b01, 1, 0, 500, 440, 0, 0);
      #3;
      Reset = 1'b1;
      #1;
      check("async_reset", 2'b00, 0, 1, 0, 0, 0, 0);
      n_vec++;
      if (bus.bullet_X !== '0 || bus.bullet_Y !== '0) begin
         n_err++;
         $display("FAIL async_reset_pos got X=%h Y=%h want 0", bus.bullet_X, bus.bullet_Y);
      end
      bus.shoot_bullet = 1'b0;
      repeat (2) @(posedge frame_clk);
      @(negedge frame_clk);
      Reset = 1'b0;
      frame(1, 12, 0, 0);
      check("post_reset_fire", 2'b01, 1, 0, 12, 440, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
